// File: rtl/lockout_timer_pkg.sv
// Shared state encoding, display widths and load-value helper for the lockout timer.
package lockout_timer_pkg;

  localparam int FAIL_W = 4;
  localparam int SECS_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SLEEPING = 2'd1,
    ST_RELEASE  = 2'd2
  } lock_state_t;

  // Clamp a seconds value to what the HEX display counter can hold.
  function automatic logic [SECS_W-1:0] sat_secs(input int unsigned v);
    if (v > int'(2**SECS_W - 1)) return {SECS_W{1'b1}};
    return SECS_W'(v);
  endfunction

endpackage

// File: rtl/lockout_timer_rise_detect.sv
// Rising-edge detector: pulse = d & ~d_q, one cycle, combinational from the registered history.
// History tracks d even in reset, so a level held across reset never looks like an edge.
module rise_detect (
  input  logic clk,
  input  logic system_reset,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge clk) begin
    d_q <= d;
  end

  assign pulse = d & ~d_q & ~system_reset;

endmodule

// File: rtl/lockout_timer.sv
// Lockout timer: counts consecutive failed passwords and times the controller's sleep period.
// Define LOCKOUT_ESCALATE_EN to double the lockout length after each completed lockout (x1,x2,x4,x8).
module lockout_timer
  import lockout_timer_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int LOCK_SECONDS = 10,
  parameter int MAX_ATTEMPTS = 3
) (
  input  logic              clk,
  input  logic              system_reset,
  input  logic              correct_password,
  input  logic              incorrect_password,
  input  logic              sleep,
  output logic              lockout_req,
  output logic              end_sleep,
  output logic [FAIL_W-1:0] fail_cnt,
  output logic [SECS_W-1:0] secs_left
);

  localparam int                  PRESC_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(CLK_HZ - 1);
  localparam logic [FAIL_W-1:0]   FAIL_MAX  = FAIL_W'(MAX_ATTEMPTS);

  logic correct_ev, incorrect_ev, sleep_ev;

  rise_detect u_rise_correct (
    .clk          (clk),
    .system_reset (system_reset),
    .d            (correct_password),
    .pulse        (correct_ev)
  );

  rise_detect u_rise_incorrect (
    .clk          (clk),
    .system_reset (system_reset),
    .d            (incorrect_password),
    .pulse        (incorrect_ev)
  );

  rise_detect u_rise_sleep (
    .clk          (clk),
    .system_reset (system_reset),
    .d            (sleep),
    .pulse        (sleep_ev)
  );

  lock_state_t         state, state_nxt;
  logic [PRESC_W-1:0]  presc, presc_nxt;
  logic [SECS_W-1:0]   secs_nxt, load_secs;
  logic [FAIL_W-1:0]   fail_nxt;
  logic                end_nxt;
  logic                done;

`ifdef LOCKOUT_ESCALATE_EN
  logic [1:0] esc_level;

  always_ff @(posedge clk) begin
    if (system_reset)
      esc_level <= 2'd0;
    else if (correct_ev)
      esc_level <= 2'd0;
    else if (done && esc_level != 2'd3)
      esc_level <= esc_level + 2'd1;
  end

  assign load_secs = sat_secs(int'(unsigned'(LOCK_SECONDS)) << esc_level);
`else
  assign load_secs = sat_secs(LOCK_SECONDS);
`endif

  always_comb begin
    state_nxt = state;
    secs_nxt  = secs_left;
    presc_nxt = presc;
    end_nxt   = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sleep_ev) begin
          state_nxt = ST_SLEEPING;
          secs_nxt  = load_secs;
          presc_nxt = PRESC_MAX;
        end
      end
      ST_SLEEPING: begin
        // Controller withdrawing sleep aborts the lockout without signalling completion.
        if (!sleep) begin
          state_nxt = ST_IDLE;
          secs_nxt  = '0;
          presc_nxt = '0;
        end else if (presc == '0) begin
          presc_nxt = PRESC_MAX;
          if (secs_left <= SECS_W'(1)) begin
            secs_nxt  = '0;
            end_nxt   = 1'b1;
            done      = 1'b1;
            state_nxt = ST_RELEASE;
          end else begin
            secs_nxt = secs_left - SECS_W'(1);
          end
        end else begin
          presc_nxt = presc - PRESC_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!sleep) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A correct entry or a served lockout both forgive earlier failures; clearing wins over counting.
  always_comb begin
    fail_nxt = fail_cnt;
    if (correct_ev || done)
      fail_nxt = '0;
    else if (incorrect_ev && fail_cnt != FAIL_MAX)
      fail_nxt = fail_cnt + FAIL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      state       <= ST_IDLE;
      presc       <= '0;
      secs_left   <= '0;
      end_sleep   <= 1'b0;
      fail_cnt    <= '0;
      lockout_req <= 1'b0;
    end else begin
      state       <= state_nxt;
      presc       <= presc_nxt;
      secs_left   <= secs_nxt;
      end_sleep   <= end_nxt;
      fail_cnt    <= fail_nxt;
      lockout_req <= (fail_nxt == FAIL_MAX);
    end
  end

endmodule

// File: tb/tb_lockout_timer.sv
// Randomised bench for lockout_timer: a reference model predicts every cycle's outputs into a
// queue; an independent monitor pops and compares after each clock edge.
module tb_lockout_timer;

  localparam int HZ = 4;
  localparam int LS = 3;
  localparam int MA = 3;

  logic       clk = 1'b0;
  logic       system_reset = 1'b1;
  logic       correct_password = 1'b0;
  logic       incorrect_password = 1'b0;
  logic       sleep = 1'b0;
  logic       lockout_req, end_sleep;
  logic [3:0] fail_cnt;
  logic [7:0] secs_left;

  lockout_timer #(.CLK_HZ(HZ), .LOCK_SECONDS(LS), .MAX_ATTEMPTS(MA)) dut (
    .clk                (clk),
    .system_reset       (system_reset),
    .correct_password   (correct_password),
    .incorrect_password (incorrect_password),
    .sleep              (sleep),
    .lockout_req        (lockout_req),
    .end_sleep          (end_sleep),
    .fail_cnt           (fail_cnt),
    .secs_left          (secs_left)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       lr;
    logic       es;
    logic [3:0] fc;
    logic [7:0] sl;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   passed = 0;
  int   n_end_model = 0;

  // Reference model: lockout progress is tracked as cycles elapsed since the load cycle.
  int  m_mode = 0;      // 0 idle, 1 timing, 2 waiting for sleep to drop
  int  m_elapsed = 0;
  int  m_total = 0;
  int  m_len_secs = 0;
  int  m_fails = 0;
  int  m_esc = 0;
  bit  p_cp = 0, p_ip = 0, p_sl = 0;

  task automatic step(input bit r, input bit cp, input bit ip, input bit sl);
    exp_t e;
    bit   cev, iev, sev, fin;
    int   mult;
    @(negedge clk);
    system_reset       = r;
    correct_password   = cp;
    incorrect_password = ip;
    sleep              = sl;
    e = '0;
    if (r) begin
      m_mode = 0; m_elapsed = 0; m_fails = 0; m_esc = 0;
    end else begin
      cev = cp && !p_cp;
      iev = ip && !p_ip;
      sev = sl && !p_sl;
      fin = 1'b0;
      if (m_mode == 1) begin
        if (!sl) begin
          m_mode = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == m_total) begin
            fin = 1'b1;
            m_mode = 2;
            n_end_model++;
          end
        end
      end else if (m_mode == 0) begin
        if (sev) begin
`ifdef LOCKOUT_ESCALATE_EN
          mult = 1 << m_esc;
`else
          mult = 1;
`endif
          m_len_secs = LS * mult;
          if (m_len_secs > 255) m_len_secs = 255;
          m_total   = m_len_secs * HZ;
          m_elapsed = 0;
          m_mode    = 1;
        end
      end else if (!sl) begin
        m_mode = 0;
      end
      if (cev || fin) m_fails = 0;
      else if (iev && m_fails < MA) m_fails++;
      if (cev) m_esc = 0;
      else if (fin && m_esc < 3) m_esc++;
      e.es = fin;
      e.fc = 4'(m_fails);
      e.lr = (m_fails == MA);
      e.sl = (m_mode == 1) ? 8'(m_len_secs - m_elapsed / HZ) : 8'd0;
    end
    p_cp = cp; p_ip = ip; p_sl = sl;
    expq.push_back(e);
  endtask

  // Monitor: every clock edge presents a fresh output word.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        if ({lockout_req, end_sleep, fail_cnt, secs_left} === e)
          passed++;
        else
          $display("FAIL outputs t=%0t got lr=%b es=%b fc=%0d secs=%0d, expected lr=%b es=%b fc=%0d secs=%0d",
                   $time, lockout_req, end_sleep, fail_cnt, secs_left, e.lr, e.es, e.fc, e.sl);
      end
    end
  end

  task automatic pulse_pw(input bit cp, input bit ip);
    step(0, cp, ip, 0);
    step(0, 0, 0, 0);
  endtask

  initial begin
    bit r, cp, ip, sl;
    repeat (2) step(1, 0, 0, 0);
    // sleep already high across reset must not start timing
    repeat (2) step(1, 0, 0, 1);
    repeat (5) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    // counting and saturation, then a correct clear
    repeat (4) pulse_pw(0, 1);
    pulse_pw(1, 0);
    // simultaneous correct and incorrect with two failures pending
    repeat (2) pulse_pw(0, 1);
    pulse_pw(1, 1);
    // full lockout with sleep held high well past completion
    repeat (3) pulse_pw(0, 1);
    repeat (20) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    // abort after a few cycles, then a fresh lockout restarts from the full length
    repeat (6) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 1);
    // reset in the middle of timing while sleep stays high
    step(1, 0, 0, 1);
    repeat (4) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    // back-to-back lockouts, then a correct entry
    repeat (3) begin
      repeat (30) step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end
    pulse_pw(1, 0);
    repeat (16) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    // sticky random levels
    r = 0; cp = 0; ip = 0; sl = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) cp = ~cp;
      if ($urandom_range(0, 5) == 0) ip = ~ip;
      if ($urandom_range(0, 23) == 0) sl = ~sl;
      step(r, cp, ip, sl);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (expq.size() == 0) passed++;
    else $display("FAIL drain got %0d pending expectations, expected 0", expq.size());
    checks++;
    if (n_end_model > 0) passed++;
    else $display("FAIL coverage got %0d completed lockouts, expected at least 1", n_end_model);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
